// File: rtl/stream_demux_if.sv
// rtl/stream_demux_if.sv - handshake bundle between a producer, the 1-to-4 demux and four consumers
interface stream_demux_if;
  logic       io_in_valid;
  logic       io_in_ready;
  logic [7:0] io_in_bits;
  logic [1:0] io_in_dest;

  logic       io_out_0_valid;
  logic       io_out_0_ready;
  logic [7:0] io_out_0_bits;
  logic       io_out_1_valid;
  logic       io_out_1_ready;
  logic [7:0] io_out_1_bits;
  logic       io_out_2_valid;
  logic       io_out_2_ready;
  logic [7:0] io_out_2_bits;
  logic       io_out_3_valid;
  logic       io_out_3_ready;
  logic [7:0] io_out_3_bits;

  modport slave (
    input  io_in_valid, io_in_bits, io_in_dest,
    output io_in_ready,
    output io_out_0_valid, io_out_0_bits, io_out_1_valid, io_out_1_bits,
    output io_out_2_valid, io_out_2_bits, io_out_3_valid, io_out_3_bits,
    input  io_out_0_ready, io_out_1_ready, io_out_2_ready, io_out_3_ready
  );

  modport master (
    output io_in_valid, io_in_bits, io_in_dest,
    input  io_in_ready,
    input  io_out_0_valid, io_out_0_bits, io_out_1_valid, io_out_1_bits,
    input  io_out_2_valid, io_out_2_bits, io_out_3_valid, io_out_3_bits,
    output io_out_0_ready, io_out_1_ready, io_out_2_ready, io_out_3_ready
  );
endinterface

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - 1-to-4 stream demux, one 2-entry FIFO per output
// STREAM_DEMUX_CNT_EN adds io_count, an 8-bit wrapping count of accepted input beats.
module stream_demux (
  input  logic          clk,
  input  logic          reset,
  stream_demux_if.slave io
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [7:0]    io_count
`endif
);

  logic [7:0] mem_q [4][2];
  logic [7:0] mem_d [4][2];
  logic [1:0] occ_q [4];
  logic [1:0] occ_d [4];
  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] rd_ptr_q, rd_ptr_d;
  logic [3:0] out_ready;
  logic [3:0] enq, deq;
  logic       in_ready;
  logic       in_fire;

  assign out_ready = {io.io_out_3_ready, io.io_out_2_ready, io.io_out_1_ready, io.io_out_0_ready};

  // Ready looks only at the addressed FIFO, so a full output never blocks the others.
  assign in_ready       = (occ_q[io.io_in_dest] != 2'd2);
  assign in_fire        = io.io_in_valid & in_ready;
  assign io.io_in_ready = in_ready;

  always_comb begin
    mem_d    = mem_q;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    enq      = '0;
    deq      = '0;
    for (int k = 0; k < 4; k++) begin
      enq[k] = in_fire && (io.io_in_dest == 2'(k));
      deq[k] = (occ_q[k] != 2'd0) && out_ready[k];
      if (enq[k]) begin
        mem_d[k][wr_ptr_q[k]] = io.io_in_bits;
        wr_ptr_d[k]           = ~wr_ptr_q[k];
      end
      if (deq[k]) begin
        rd_ptr_d[k] = ~rd_ptr_q[k];
      end
      case ({enq[k], deq[k]})
        2'b10:   occ_d[k] = occ_q[k] + 2'd1;
        2'b01:   occ_d[k] = occ_q[k] - 2'd1;
        default: occ_d[k] = occ_q[k];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q    <= '{default: 2'd0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage carries no reset; validity comes solely from occupancy.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign io.io_out_0_valid = (occ_q[0] != 2'd0);
  assign io.io_out_1_valid = (occ_q[1] != 2'd0);
  assign io.io_out_2_valid = (occ_q[2] != 2'd0);
  assign io.io_out_3_valid = (occ_q[3] != 2'd0);
  assign io.io_out_0_bits  = mem_q[0][rd_ptr_q[0]];
  assign io.io_out_1_bits  = mem_q[1][rd_ptr_q[1]];
  assign io.io_out_2_bits  = mem_q[2][rd_ptr_q[2]];
  assign io.io_out_3_bits  = mem_q[3][rd_ptr_q[3]];

`ifdef STREAM_DEMUX_CNT_EN
  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q + {7'd0, in_fire};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign io_count = count_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - directed and random checks of stream_demux against a per-output scoreboard
module tb_stream_demux;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] out_ready = 4'b0000;
  logic [3:0] out_valid;
  logic [7:0] out_bits [4];
`ifdef STREAM_DEMUX_CNT_EN
  logic [7:0] io_count;
`endif

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int fires  = 0;
  logic [7:0] exp_q [4][$];

  stream_demux_if bus ();

  stream_demux dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
`ifdef STREAM_DEMUX_CNT_EN
    ,
    .io_count (io_count)
`endif
  );

  always #5 clk = ~clk;

  assign bus.io_out_0_ready = out_ready[0];
  assign bus.io_out_1_ready = out_ready[1];
  assign bus.io_out_2_ready = out_ready[2];
  assign bus.io_out_3_ready = out_ready[3];
  assign out_valid = {bus.io_out_3_valid, bus.io_out_2_valid, bus.io_out_1_valid, bus.io_out_0_valid};
  assign out_bits[0] = bus.io_out_0_bits;
  assign out_bits[1] = bus.io_out_1_bits;
  assign out_bits[2] = bus.io_out_2_bits;
  assign out_bits[3] = bus.io_out_3_bits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: at the falling edge retire output fires against the scoreboard, record the input fire.
  task automatic cycle();
    logic [7:0] e;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (out_valid[k] && out_ready[k]) begin
        check($sformatf("sb_nonempty_%0d", k), 32'(exp_q[k].size() != 0), 32'd1);
        if (exp_q[k].size() != 0) begin
          e = exp_q[k].pop_front();
          check($sformatf("out_%0d_bits", k), 32'(out_bits[k]), 32'(e));
        end
      end
    end
    if (bus.io_in_valid && bus.io_in_ready) begin
      exp_q[bus.io_in_dest].push_back(bus.io_in_bits);
      fires++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] d, input logic [7:0] b);
    bus.io_in_valid = v;
    bus.io_in_dest  = d;
    bus.io_in_bits  = b;
  endtask

  initial begin
    drive(1'b0, 2'd0, 8'h00);
    #3;
    check("rst_in_ready", 32'(bus.io_in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(bus.io_in_ready), 32'd1);
`ifdef STREAM_DEMUX_CNT_EN
    check("count_after_reset", 32'(io_count), 32'd0);
`endif

    // Single beat to output 2 with one-cycle latency
    drive(1'b1, 2'd2, 8'hA5);
    cycle();
    drive(1'b0, 2'd2, 8'h00);
    check("lat_out2_valid", 32'(out_valid[2]), 32'd1);
    check("lat_out2_bits", 32'(out_bits[2]), 32'hA5);
    check("lat_others_invalid", 32'({out_valid[3], out_valid[1], out_valid[0]}), 32'd0);
    out_ready[2] = 1'b1;
    cycle();
    out_ready[2] = 1'b0;
    check("out2_drained", 32'(out_valid[2]), 32'd0);

    // Fill FIFO 1 with its consumer stalled
    drive(1'b1, 2'd1, 8'h11);
    check("f1_ready_0", 32'(bus.io_in_ready), 32'd1);
    cycle();
    drive(1'b1, 2'd1, 8'h22);
    check("f1_ready_1", 32'(bus.io_in_ready), 32'd1);
    cycle();
    drive(1'b1, 2'd1, 8'h33);
    check("f1_full_ready", 32'(bus.io_in_ready), 32'd0);
    cycle();
    check("f1_still_full", 32'(bus.io_in_ready), 32'd0);

    // A full FIFO 1 does not block output 3
    drive(1'b1, 2'd3, 8'h7E);
    check("f3_ready_while_f1_full", 32'(bus.io_in_ready), 32'd1);
    cycle();
    drive(1'b0, 2'd3, 8'h00);
    check("f3_valid", 32'(out_valid[3]), 32'd1);
    check("f3_bits", 32'(out_bits[3]), 32'h7E);

    // Full FIFO refuses enqueue even while dequeuing, then drains in order
    drive(1'b1, 2'd1, 8'h33);
    out_ready[1] = 1'b1;
    check("full_deq_refuses", 32'(bus.io_in_ready), 32'd0);
    cycle();
    check("f1_ready_after_pop", 32'(bus.io_in_ready), 32'd1);
    cycle();
    drive(1'b0, 2'd1, 8'h00);
    cycle();
    check("f1_empty", 32'(out_valid[1]), 32'd0);
    out_ready[1] = 1'b0;
    out_ready[3] = 1'b1;
    cycle();
    out_ready[3] = 1'b0;
    check("f3_empty", 32'(out_valid[3]), 32'd0);

    // Simultaneous enqueue/dequeue at occupancy 1
    drive(1'b1, 2'd0, 8'h01);
    cycle();
    drive(1'b1, 2'd0, 8'h02);
    out_ready[0] = 1'b1;
    cycle();
    drive(1'b0, 2'd0, 8'h00);
    check("swap_valid", 32'(out_valid[0]), 32'd1);
    check("swap_head", 32'(out_bits[0]), 32'h02);
    cycle();
    check("swap_occ_was_1", 32'(out_valid[0]), 32'd0);
    out_ready[0] = 1'b0;

    // Asynchronous reset mid-cycle with FIFOs 0 and 2 occupied
    drive(1'b1, 2'd0, 8'h44);
    cycle();
    drive(1'b1, 2'd2, 8'h55);
    cycle();
    drive(1'b1, 2'd0, 8'h66);
    check("pre_rst_valid", 32'(out_valid), 32'b0101);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_ready", 32'(bus.io_in_ready), 32'd1);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    drive(1'b0, 2'd0, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    fires = 0;
    check("post_rst_valid", 32'(out_valid), 32'd0);

`ifdef STREAM_DEMUX_CNT_EN
    check("count_cleared", 32'(io_count), 32'd0);
    out_ready = 4'b1111;
    for (int i = 0; i < 400 && fires < 257; i++) begin
      drive(1'b1, 2'(i % 4), 8'(i));
      cycle();
    end
    drive(1'b0, 2'd0, 8'h00);
    check("count_fires", 32'(fires), 32'd257);
    check("count_wrap", 32'(io_count), 32'd1);
    repeat (2) cycle();
    out_ready = 4'b0000;
`endif

    // Random traffic with random back-pressure
    for (int i = 0; i < 120; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      out_ready = 4'($urandom_range(0, 15));
      cycle();
    end
    drive(1'b0, 2'd0, 8'h00);
    out_ready = 4'b1111;
    for (int i = 0; i < 10; i++) cycle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_sb_%0d", k), 32'(exp_q[k].size()), 32'd0);
    end
    check("drain_valid", 32'(out_valid), 32'd0);
`ifdef STREAM_DEMUX_CNT_EN
    check("count_random", 32'(io_count), 32'(8'(fires)));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, sole clock; all state updates on the rising edge.
REQ-002 The block SHALL have these ports: reset, input, 1, asynchronous, active-high; asserting it clears all state immediately, independent of clk.
REQ-003 The block SHALL have these ports: io_in_valid, input, 1, producer offers a beat.
REQ-004 The block SHALL have these ports: io_in_ready, output, 1, block accepts the offered beat this cycle.
REQ-005 The block SHALL have these ports: io_in_bits, input, 8, payload.
REQ-006 The block SHALL have these ports: io_in_dest, input, 2, destination output index 0..3.
REQ-007 The block SHALL have these ports: io_out_k_valid, output, 1, for k=0..3, output k holds a beat.
REQ-008 The block SHALL have these ports: io_out_k_ready, input, 1, for k=0..3, consumer k takes the beat.
REQ-009 The block SHALL have these ports: io_out_k_bits, output, 8, for k=0..3, head payload of output k.
REQ-010 The block SHALL have these ports when STREAM_DEMUX_CNT_EN is defined: io_count, output, 8, accepted-input beat count.

Function
REQ-011 The block SHALL contain one independent 2-entry FIFO per output (payload 8 bits, occupancy 0..2, read/write pointers 1 bit each, wrap 1->0).
REQ-012 The block SHALL set io_in_ready = (occupancy of FIFO[io_in_dest] < 2), combinationally from io_in_dest and registered state only; it SHALL NOT depend on any io_out_k_ready.
REQ-013 The block SHALL treat an input fire as io_in_valid & io_in_ready; on fire, the block SHALL write io_in_bits into FIFO[io_in_dest] at the next edge.
REQ-014 The block SHALL set io_out_k_valid = (occupancy_k != 0), and io_out_k_bits SHALL equal the head entry of FIFO k; the outputs SHALL be registered, with no input-to-output combinational path.
REQ-015 The block SHALL treat an output fire on k as io_out_k_valid & io_out_k_ready; on fire, the block SHALL advance the head of FIFO k.
REQ-016 Latency SHALL be exactly 1 cycle: a beat accepted at edge N SHALL be visible on its output after edge N (valid in cycle N+1) when that FIFO was empty.
REQ-017 Simultaneous enqueue and dequeue on the same FIFO SHALL leave occupancy unchanged, and both operations SHALL complete; when occupancy is 2, enqueue SHALL be refused even if dequeue fires the same cycle.
REQ-018 A full FIFO SHALL NOT stall other outputs: io_in_ready SHALL depend only on the FIFO addressed by io_in_dest.
REQ-019 Beats to the same destination SHALL emerge in acceptance order; no ordering SHALL be guaranteed across destinations.
REQ-020 When io_in_valid=0, io_in_ready SHALL still reflect the addressed FIFO's state, and no write SHALL occur.
REQ-021 The block SHALL never drop or duplicate a beat.

Reset
REQ-022 On reset assertion, the block SHALL immediately clear all occupancies and pointers to 0, and set io_out_k_valid=0 for all k.
REQ-023 During reset, io_in_ready SHALL be 1; FIFO payload storage need not be cleared.
REQ-024 Beats in flight at reset SHALL be discarded, and no partial update SHALL survive.
REQ-025 When STREAM_DEMUX_CNT_EN is defined, reset SHALL set io_count=0.

Configuration
REQ-026 With STREAM_DEMUX_CNT_EN defined, io_count SHALL exist as an 8-bit register that increments by 1 on each input fire and wraps 255->0.
REQ-027 With STREAM_DEMUX_CNT_EN undefined, io_count and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL cover: after reset, all out_valid=0 and in_ready=1 -> drive dest=2, bits=0xA5, one cycle -> out_2_valid=1 with bits=0xA5 next cycle; out_0, out_1 and out_3 stay invalid.
REQ-029 The bench SHALL cover: hold out_1_ready=0, send 0x11, 0x22 and 0x33 to dest=1 -> first two accepted, in_ready=0 on the third; raise out_1_ready -> outputs 0x11 then 0x22, then 0x33 is accepted.
REQ-030 The bench SHALL cover: FIFO 1 full, send dest=3 bits=0x7E -> accepted immediately, and out_3 shows 0x7E one cycle later.
REQ-031 The bench SHALL cover: FIFO 0 at occupancy 1 with simultaneous enqueue 0x02 and dequeue of 0x01 -> occupancy stays 1 and head becomes 0x02.
REQ-032 The bench SHALL cover: assert reset asynchronously mid-cycle with FIFOs 0 and 2 non-empty -> all out_valid drop before the next clk edge and in_ready=1.
REQ-033 The bench SHALL cover, with STREAM_DEMUX_CNT_EN defined: 257 accepted beats -> io_count=1.
